// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor sequencer.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: D = a - b - c, Bout set when the bit underflows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic D,
  output logic Bout
);

  assign D    = a ^ b ^ c;
  assign Bout = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_sub_seq.sv
// Bit-serial WIDTH-bit subtractor: one operand pair per handshake, LSB-first through one full_subtractor.
// Optional zero/ovf flags are built when SERIAL_SUB_FLAGS_EN is defined.
module serial_sub_seq
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUB_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, and a DONE result holds until taken.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr, diff_next;
  logic             brw, fs_d, fs_bout;
  logic [CW-1:0]    cnt;
  logic             accept, last;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c    (brw),
    .D    (fs_d),
    .Bout (fs_bout)
  );

  // Difference bits enter at the MSB and walk down, so after WIDTH edges bit 0 is in place.
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_next = fs_d;
    end else begin : g_wn
      assign diff_next = {fs_d, diff_sr[WIDTH-1:1]};
    end
  endgenerate

  assign accept    = (state_q == IDLE) && in_valid;
  assign last      = (state_q == RUN) && (cnt == CNT_LAST);
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
      diff    <= '0;
      bout    <= 1'b0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      brw     <= bin;
      cnt     <= '0;
      diff_sr <= '0;
    end else if (state_q == RUN) begin
      diff_sr <= diff_next;
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      brw     <= fs_bout;
      cnt     <= cnt + CW'(1);
      if (last) begin
        diff <= diff_next;
        bout <= fs_bout;
      end
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb, b_msb;

  // Operand sign bits are captured at accept because the shift registers lose them during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (last) begin
      zero <= (diff_next == '0);
      ovf  <= (a_msb ^ b_msb) & (a_msb ^ diff_next[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub_seq.sv
// Bench for serial_sub_seq: WIDTH=8 instance with scoreboard and random traffic, plus a WIDTH=1 instance.
module tb_serial_sub_seq;

  localparam int W  = 8;
  localparam int TW = W + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, bin, out_valid, out_ready;
  logic [W-1:0] a, b, diff;
  logic         bout;
  logic [1:0]   state_dbg;
  logic         in_valid_1, in_ready_1, bin_1, out_valid_1, out_ready_1;
  logic [0:0]   a_1, b_1, diff_1;
  logic         bout_1;
  logic [1:0]   state_dbg_1;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero, ovf, zero_1, ovf_1;
`endif

  serial_sub_seq #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .bout(bout),
`ifdef SERIAL_SUB_FLAGS_EN
    .zero(zero), .ovf(ovf),
`endif
    .state_dbg(state_dbg)
  );

  serial_sub_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1), .a(a_1), .b(b_1), .bin(bin_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .diff(diff_1), .bout(bout_1),
`ifdef SERIAL_SUB_FLAGS_EN
    .zero(zero_1), .ovf(ovf_1),
`endif
    .state_dbg(state_dbg_1)
  );

  // ---------------- clock / reset / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  logic [TW-1:0] exp_q[$];
  int            acc_q[$];
  logic [3:0]    exp1_q[$];
  int            acc1_q[$];
  logic          busy      = 1'b0;
  logic          force_low = 1'b0;
  logic          ov_prev   = 1'b0;
  int            hs_cyc    = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer subtraction; packed as {bout, zero, ovf, diff}.
  function automatic logic [TW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int r;
    logic [W-1:0] d;
    logic bo, z, o;
    r  = int'(x) - int'(y) - int'(c);
    bo = (r < 0);
    d  = r[W-1:0];
    z  = (d == '0);
    o  = (x[W-1] ^ y[W-1]) & (x[W-1] ^ d[W-1]);
    return {bo, z, o, d};
  endfunction

  function automatic logic [3:0] model1(input logic x, input logic y, input logic c);
    int r;
    logic d;
    r = int'(x) - int'(y) - int'(c);
    d = r[0];
    return {r < 0, d == 1'b0, (x ^ y) & (x ^ d), d};
  endfunction

  // ---------------- driver tasks
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, output int acc);
    int n = 0;
    acc = -1;
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; bin = c;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready never rose, required 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    exp_q.push_back(model(x, y, c));
    acc_q.push_back(cyc);
    busy     = 1'b1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'b0;
  endtask

  task automatic send1(input logic x, input logic y, input logic c);
    int n = 0;
    @(posedge clk); #1;
    in_valid_1 = 1'b1; a_1 = x; b_1 = y; bin_1 = c;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready_1 && n < 50);
    if (!in_ready_1) begin
      total++; bad++;
      $display("FAIL accept1_timeout: in_ready never rose, required 1");
      in_valid_1 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    exp1_q.push_back(model1(x, y, c));
    acc1_q.push_back(cyc);
    in_valid_1 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size() + exp1_q.size());
    end
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitors / scoreboard
  always @(negedge clk) begin
    logic [TW-1:0] e;
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      check("in_ready", {31'b0, in_ready}, {31'b0, !busy});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: diff=%0h with empty expected queue, required no out_valid", diff);
        end else begin
          e = exp_q[0];
          if (!ov_prev) check("latency", cyc - acc_q[0], W);
          check("diff", {24'b0, diff}, {24'b0, e[W-1:0]});
          check("bout", {31'b0, bout}, {31'b0, e[W+2]});
`ifdef SERIAL_SUB_FLAGS_EN
          check("zero", {31'b0, zero}, {31'b0, e[W+1]});
          check("ovf",  {31'b0, ovf},  {31'b0, e[W]});
`endif
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            busy   = 1'b0;
            hs_cyc = cyc + 1;
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e1;
    if (!rst && out_valid_1) begin
      if (exp1_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out1: diff=%0h with empty expected queue, required no out_valid", diff_1);
      end else begin
        e1 = exp1_q.pop_front();
        check("w1_latency", cyc - acc1_q.pop_front(), 1);
        check("w1_diff", {31'b0, diff_1}, {31'b0, e1[0]});
        check("w1_bout", {31'b0, bout_1}, {31'b0, e1[3]});
`ifdef SERIAL_SUB_FLAGS_EN
        check("w1_zero", {31'b0, zero_1}, {31'b0, e1[2]});
        check("w1_ovf",  {31'b0, ovf_1},  {31'b0, e1[1]});
`endif
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {31'b0, in_ready},  32'd1);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_diff"},      {24'b0, diff},      32'd0);
    check({tag, "_bout"},      {31'b0, bout},      32'd0);
    check({tag, "_state"},     {30'b0, state_dbg}, 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
    check({tag, "_zero"}, {31'b0, zero}, 32'd0);
    check({tag, "_ovf"},  {31'b0, ovf},  32'd0);
`endif
  endtask

  // ---------------- main sequence
  initial begin
    int acc_a, acc_b, dummy;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
    in_valid_1 = 1'b0; a_1 = '0; b_1 = '0; bin_1 = 1'b0;
    out_ready_1 = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // directed cases
    send(8'h35, 8'h12, 1'b0, dummy);
    send(8'h00, 8'h01, 1'b0, dummy);
    send(8'h80, 8'h01, 1'b0, dummy);
    send(8'h10, 8'h0F, 1'b1, dummy);
    drain();

    // stall in DONE with the next pair already presented
    force_low = 1'b1;
    send(8'h5A, 8'h33, 1'b0, acc_a);
    fork
      send(8'h44, 8'h11, 1'b0, acc_b);
      begin
        int n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(negedge clk);
        force_low = 1'b0;
      end
    join
    check("reaccept_edge", acc_b, hs_cyc + 1);
    drain();

    // asynchronous reset in the middle of RUN
    send(8'h77, 8'h11, 1'b0, dummy);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    acc_q.delete();
    busy = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    send(8'h05, 8'h03, 1'b0, dummy);
    drain();

    // random traffic
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), dummy);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    // single-bit instance
    send1(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
